// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter
// Four-way round-robin arbiter for a shared capture register.
// A granted requester has its DIN slice captured into Q one cycle after the
// grant, then keeps the grant while its REQ stays high, up to HOLD_MAX cycles.
//
// Ports
//   CLK      : clock, rising edge
//   RST      : asynchronous active-low reset
//   REQ      : per-requester request, level-sensitive
//   DIN      : requester data, slice i = DIN[i*DATA_WIDTH +: DATA_WIDTH]
//   GNT      : one-hot grant (all zero when idle), registered
//   OWNER    : index of current or last granted requester, registered
//   Q        : shared capture register
//   Q_VALID  : one-cycle pulse when Q is updated
//   BUSY     : high in GRANT and HOLD
//   TIMEOUT  : one-cycle pulse when a grant is revoked by the HOLD_MAX limit
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no grant; arbitrate among REQ starting at ptr
// ST_GRANT | grant issued; capture owner's DIN slice on exit
// ST_HOLD  | owner keeps grant while REQ[OWNER] high, bounded by HOLD_MAX
module reg_access_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int HOLD_MAX   = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [3:0]              REQ,
    input  logic [4*DATA_WIDTH-1:0] DIN,
    output logic [3:0]              GNT,
    output logic [1:0]              OWNER,
    output logic [DATA_WIDTH-1:0]   Q,
    output logic                    Q_VALID,
    output logic                    BUSY,
    output logic                    TIMEOUT
);

    localparam int CW = $clog2(HOLD_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [1:0]            ptr, ptr_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [3:0]            gnt_nxt;
    logic [1:0]            owner_nxt;
    logic [DATA_WIDTH-1:0] q_nxt;
    logic                  q_valid_nxt;
    logic                  busy_nxt;
    logic                  timeout_nxt;

    logic [1:0]            winner;
    logic [1:0]            idx;
    logic                  found;
    logic [DATA_WIDTH-1:0] din_slice [4];

    for (genvar g = 0; g < 4; g++) begin : g_slice
        assign din_slice[g] = DIN[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: ptr, ptr+1, ptr+2, ptr+3 (mod 4), first hit wins.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && REQ[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        gnt_nxt     = GNT;
        owner_nxt   = OWNER;
        q_nxt       = Q;
        q_valid_nxt = 1'b0;
        busy_nxt    = BUSY;
        timeout_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                gnt_nxt  = 4'b0000;
                busy_nxt = 1'b0;
                if (found) begin
                    gnt_nxt   = 4'b0001 << winner;
                    owner_nxt = winner;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Capture happens regardless of REQ[OWNER] dropping here.
                q_nxt       = din_slice[OWNER];
                q_valid_nxt = 1'b1;
                cnt_nxt     = '0;
                state_nxt   = ST_HOLD;
            end
            ST_HOLD: begin
                if (!REQ[OWNER] || (cnt == CW'(HOLD_MAX - 1))) begin
                    gnt_nxt     = 4'b0000;
                    busy_nxt    = 1'b0;
                    ptr_nxt     = OWNER + 2'd1;
                    timeout_nxt = REQ[OWNER];
                    state_nxt   = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                gnt_nxt   = 4'b0000;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            ptr     <= 2'd0;
            cnt     <= '0;
            GNT     <= 4'b0000;
            OWNER   <= 2'd0;
            Q       <= '0;
            Q_VALID <= 1'b0;
            BUSY    <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            GNT     <= gnt_nxt;
            OWNER   <= owner_nxt;
            Q       <= q_nxt;
            Q_VALID <= q_valid_nxt;
            BUSY    <= busy_nxt;
            TIMEOUT <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter (DATA_WIDTH=8, HOLD_MAX=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_reg_access_arbiter;

    localparam int DW = 8;
    localparam int HM = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [3:0]    REQ;
    logic [4*DW-1:0] DIN;
    logic [3:0]    GNT;
    logic [1:0]    OWNER;
    logic [DW-1:0] Q;
    logic          Q_VALID;
    logic          BUSY;
    logic          TIMEOUT;

    int pass_cnt  = 0;
    int total_cnt = 0;

    reg_access_arbiter #(.DATA_WIDTH(DW), .HOLD_MAX(HM)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DIN(DIN),
        .GNT(GNT), .OWNER(OWNER), .Q(Q), .Q_VALID(Q_VALID),
        .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        REQ = 4'b0000;
        DIN = '0;
        step();
        step();
        RST = 1'b1;
    endtask

    task automatic test_reset();
        REQ = 4'b1111;
        DIN = 32'hFFFF_FFFF;
        RST = 1'b0;
        #2;
        total_cnt++;
        if ({GNT, OWNER, Q, Q_VALID, BUSY, TIMEOUT} !== 19'd0)
            $display("FAIL reset_outputs got gnt=%b owner=%0d q=%h qv=%b busy=%b to=%b exp all zero",
                     GNT, OWNER, Q, Q_VALID, BUSY, TIMEOUT);
        else pass_cnt++;
        do_reset();
        // First edge after release must arbitrate from ptr=0.
        REQ = 4'b1010;
        step();
        total_cnt++;
        if (GNT !== 4'b0010 || OWNER !== 2'd1)
            $display("FAIL reset_first_arb got gnt=%b owner=%0d exp gnt=0010 owner=1", GNT, OWNER);
        else pass_cnt++;
    endtask

    task automatic test_single();
        do_reset();
        DIN = 32'h0000_00A5;
        REQ = 4'b0001;
        step();
        total_cnt++;
        if (GNT !== 4'b0001 || BUSY !== 1'b1 || OWNER !== 2'd0 || Q_VALID !== 1'b0)
            $display("FAIL single_grant got gnt=%b busy=%b owner=%0d qv=%b exp 0001 1 0 0",
                     GNT, BUSY, OWNER, Q_VALID);
        else pass_cnt++;
        step();
        total_cnt++;
        if (Q !== 8'hA5 || Q_VALID !== 1'b1 || GNT !== 4'b0001)
            $display("FAIL single_capture got q=%h qv=%b gnt=%b exp a5 1 0001", Q, Q_VALID, GNT);
        else pass_cnt++;
        DIN = 32'h0000_0077;
        step();
        total_cnt++;
        if (Q_VALID !== 1'b0 || GNT !== 4'b0001 || Q !== 8'hA5)
            $display("FAIL single_hold got qv=%b gnt=%b q=%h exp 0 0001 a5", Q_VALID, GNT, Q);
        else pass_cnt++;
        REQ = 4'b0000;
        step();
        total_cnt++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0 || OWNER !== 2'd0 || Q !== 8'hA5 || TIMEOUT !== 1'b0)
            $display("FAIL single_release got gnt=%b busy=%b owner=%0d q=%h to=%b exp 0000 0 0 a5 0",
                     GNT, BUSY, OWNER, Q, TIMEOUT);
        else pass_cnt++;
        step();
        total_cnt++;
        if (GNT !== 4'b0000 || OWNER !== 2'd0)
            $display("FAIL single_idle got gnt=%b owner=%0d exp 0000 0", GNT, OWNER);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        DIN = 32'h4433_2211;
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            total_cnt++;
            if (GNT !== (4'b0001 << exp_seq[k]) || OWNER !== 2'(exp_seq[k]))
                $display("FAIL rr_grant%0d got gnt=%b owner=%0d exp owner=%0d", k, GNT, OWNER, exp_seq[k]);
            else pass_cnt++;
            step();
            total_cnt++;
            if (Q !== exp_q[exp_seq[k]] || Q_VALID !== 1'b1)
                $display("FAIL rr_capture%0d got q=%h qv=%b exp %h 1", k, Q, Q_VALID, exp_q[exp_seq[k]]);
            else pass_cnt++;
            REQ[exp_seq[k]] = 1'b0;
            step();
            total_cnt++;
            if (GNT !== 4'b0000 || BUSY !== 1'b0)
                $display("FAIL rr_gap%0d got gnt=%b busy=%b exp 0000 0", k, GNT, BUSY);
            else pass_cnt++;
            REQ = 4'b1111;
        end
        REQ = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        int gnt_cycles = 0;
        int to_pulses  = 0;
        do_reset();
        DIN = 32'h00BE_0000;
        REQ = 4'b0100;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (GNT === 4'b0100) gnt_cycles++;
            if (TIMEOUT === 1'b1) to_pulses++;
            if (k == 6) begin
                total_cnt++;
                if (TIMEOUT !== 1'b1 || GNT !== 4'b0000 || BUSY !== 1'b0)
                    $display("FAIL timeout_edge got to=%b gnt=%b busy=%b exp 1 0000 0", TIMEOUT, GNT, BUSY);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (gnt_cycles != 5)
            $display("FAIL timeout_gnt_len got %0d exp 5", gnt_cycles);
        else pass_cnt++;
        total_cnt++;
        if (to_pulses != 1)
            $display("FAIL timeout_pulses got %0d exp 1", to_pulses);
        else pass_cnt++;
        step();
        total_cnt++;
        if (GNT !== 4'b0100 || OWNER !== 2'd2 || TIMEOUT !== 1'b0)
            $display("FAIL timeout_regrant got gnt=%b owner=%0d to=%b exp 0100 2 0", GNT, OWNER, TIMEOUT);
        else pass_cnt++;
        REQ = 4'b0000;
        step();
        step();
    endtask

    task automatic test_rotation();
        do_reset();
        REQ = 4'b0010;
        step();
        step();
        REQ = 4'b0000;
        step();
        REQ = 4'b1011;
        step();
        total_cnt++;
        if (GNT !== 4'b1000 || OWNER !== 2'd3)
            $display("FAIL rotation_winner got gnt=%b owner=%0d exp 1000 3", GNT, OWNER);
        else pass_cnt++;
        // Non-owner request changes during GRANT/HOLD are ignored.
        REQ = 4'b1111;
        step();
        REQ = 4'b1001;
        step();
        total_cnt++;
        if (GNT !== 4'b1000 || OWNER !== 2'd3)
            $display("FAIL rotation_nonowner got gnt=%b owner=%0d exp 1000 3", GNT, OWNER);
        else pass_cnt++;
        REQ = 4'b0000;
        step();
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        DIN = 32'h0000_5A00;
        REQ = 4'b0010;
        step();
        step();
        step();
        total_cnt++;
        if (GNT !== 4'b0010 || Q !== 8'h5A)
            $display("FAIL rst_hold_setup got gnt=%b q=%h exp 0010 5a", GNT, Q);
        else pass_cnt++;
        RST = 1'b0;
        #2;
        total_cnt++;
        if ({GNT, OWNER, Q, Q_VALID, BUSY, TIMEOUT} !== 19'd0)
            $display("FAIL rst_hold_async got gnt=%b owner=%0d q=%h qv=%b busy=%b to=%b exp all zero",
                     GNT, OWNER, Q, Q_VALID, BUSY, TIMEOUT);
        else pass_cnt++;
        step();
        REQ = 4'b0011;
        DIN = 32'h0000_5A3C;
        RST = 1'b1;
        #1;
        total_cnt++;
        if (Q_VALID !== 1'b0 || TIMEOUT !== 1'b0)
            $display("FAIL rst_hold_nopulse got qv=%b to=%b exp 0 0", Q_VALID, TIMEOUT);
        else pass_cnt++;
        step();
        total_cnt++;
        if (GNT !== 4'b0001 || OWNER !== 2'd0)
            $display("FAIL rst_hold_regrant got gnt=%b owner=%0d exp 0001 0", GNT, OWNER);
        else pass_cnt++;
        step();
        total_cnt++;
        if (Q !== 8'h3C || Q_VALID !== 1'b1)
            $display("FAIL rst_hold_capture got q=%h qv=%b exp 3c 1", Q, Q_VALID);
        else pass_cnt++;
        REQ = 4'b0000;
        step();
    endtask

    task automatic test_late_drop();
        do_reset();
        DIN = 32'h0000_00C3;
        REQ = 4'b0001;
        step();
        REQ = 4'b0000;
        step();
        total_cnt++;
        if (Q !== 8'hC3 || Q_VALID !== 1'b1 || GNT !== 4'b0001)
            $display("FAIL late_capture got q=%h qv=%b gnt=%b exp c3 1 0001", Q, Q_VALID, GNT);
        else pass_cnt++;
        step();
        total_cnt++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0 || Q_VALID !== 1'b0 || TIMEOUT !== 1'b0)
            $display("FAIL late_release got gnt=%b busy=%b qv=%b to=%b exp 0000 0 0 0",
                     GNT, BUSY, Q_VALID, TIMEOUT);
        else pass_cnt++;
    endtask

    initial begin
        RST = 1'b0;
        REQ = 4'b0000;
        DIN = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_rotation();
        test_reset_in_hold();
        test_late_drop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
